contador_arbitro: RTL and testbench

Round-robin arbiter and sequencer that shares one WIDTH-bit binary up-counter between two requesters. Each requester asks for a count run from 0 up to its own limit. The block grants the counter to one requester at a time, runs the count, and signals completion with a one-cycle done pulse. It sits in front of the structural binary counter datapath and is the only block that drives its count.

---
 rtl/contador_arbitro.sv | 104 ++++++++++
 tb/tb_contador_arbitro.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/contador_arbitro.sv
// Round-robin arbiter/sequencer sharing one up-counter between two requesters.
// Each granted run counts 0..limit, pulses done, then frees the counter.
module contador_arbitro #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req,
    input  logic [WIDTH-1:0] lim0,
    input  logic [WIDTH-1:0] lim1,
    output logic [1:0]       gnt,
    output logic [1:0]       done,
    output logic [WIDTH-1:0] q,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] lim_q, lim_d;
    logic [1:0]       gnt_q, gnt_d;
    logic [1:0]       done_q, done_d;
    // prio_q=1 means requester 1 wins a tie
    logic             prio_q, prio_d;
    logic             win;

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        lim_d   = lim_q;
        gnt_d   = gnt_q;
        done_d  = done_q;
        prio_d  = prio_q;
        win     = 1'b0;
        unique case (state_q)
            IDLE: begin
                q_d    = '0;
                gnt_d  = 2'b00;
                done_d = 2'b00;
                if (|req) begin
                    win     = (req == 2'b10) || ((req == 2'b11) && prio_q);
                    gnt_d   = win ? 2'b10 : 2'b01;
                    lim_d   = win ? lim1 : lim0;
                    state_d = COUNT;
                end
            end
            COUNT: begin
                if (!(|(req & gnt_q))) begin
                    state_d = IDLE;
                    gnt_d   = 2'b00;
                    q_d     = '0;
                    prio_d  = gnt_q[0];
                end else if (q_q != lim_q) begin
                    q_d = q_q + WIDTH'(1);
                end else begin
                    state_d = DONE;
                    done_d  = gnt_q;
                end
            end
            DONE: begin
                state_d = IDLE;
                gnt_d   = 2'b00;
                done_d  = 2'b00;
                q_d     = '0;
                prio_d  = gnt_q[0];
            end
            default: begin
                state_d = IDLE;
                gnt_d   = 2'b00;
                done_d  = 2'b00;
                q_d     = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            q_q     <= '0;
            lim_q   <= '0;
            gnt_q   <= 2'b00;
            done_q  <= 2'b00;
            prio_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            lim_q   <= lim_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            prio_q  <= prio_d;
        end
    end

    assign gnt  = gnt_q;
    assign done = done_q;
    assign q    = q_q;
    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_contador_arbitro.sv
// Scoreboard bench for contador_arbitro: directed runs push expected
// grant/done/release events, a negedge monitor pops and compares them.
module tb_contador_arbitro;

    localparam int WIDTH = 4;
    localparam int EV_G = 0;
    localparam int EV_D = 1;
    localparam int EV_R = 2;

    logic             clk;
    logic             rst;
    logic [1:0]       req;
    logic [WIDTH-1:0] lim0;
    logic [WIDTH-1:0] lim1;
    logic [1:0]       gnt;
    logic [1:0]       done;
    logic [WIDTH-1:0] q;
    logic             busy;

    typedef struct {
        int kind;
        int vec;
        int qv;
        int lat;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;

    contador_arbitro #(.WIDTH(WIDTH)) dut (
        .clk  (clk),
        .rst  (rst),
        .req  (req),
        .lim0 (lim0),
        .lim1 (lim1),
        .gnt  (gnt),
        .done (done),
        .q    (q),
        .busy (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int want);
        checks++;
        if (act != want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, want, $time);
        end
    endtask

    function automatic void push(input int k, input int v, input int qv, input int lat);
        ev_t e;
        e.kind = k;
        e.vec  = v;
        e.qv   = qv;
        e.lat  = lat;
        exp_q.push_back(e);
    endfunction

    task automatic got(input int k, input int v, input int qv, input int lat);
        ev_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: got kind %0d vec %0d expected none at %0t",
                     k, v, $time);
        end else begin
            e = exp_q.pop_front();
            chk("event_kind", k, e.kind);
            if (k != EV_R) chk("event_vec", v, e.vec);
            if (k == EV_D) begin
                chk("done_q", qv, e.qv);
                chk("done_latency", lat, e.lat);
            end
            if (k == EV_G && e.lat >= 0) chk("grant_gap", lat, e.lat);
        end
    endtask

    // monitor
    logic [1:0] prev_gnt = 2'b00;
    int cyc   = 0;
    int ncyc  = 0;
    int t_rel = -1000;

    always @(negedge clk) begin
        cyc++;
        if (prev_gnt == 2'b00 && gnt != 2'b00) begin
            ncyc = 0;
            got(EV_G, int'(gnt), int'(q), cyc - t_rel);
            chk("busy_at_grant", int'(busy), 1);
        end else if (gnt != 2'b00) begin
            ncyc++;
        end
        if (gnt != 2'b00 && done == 2'b00) chk("q_progress", int'(q), ncyc);
        if (done != 2'b00) got(EV_D, int'(done), int'(q), ncyc);
        if (prev_gnt != 2'b00 && gnt == 2'b00) begin
            got(EV_R, 0, int'(q), 0);
            chk("q_after_release", int'(q), 0);
            chk("busy_after_release", int'(busy), 0);
            t_rel = cyc;
        end
        prev_gnt = gnt;
    end

    task automatic wait_done(input logic [1:0] v);
        int n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (done != v && n < 64);
        if (done != v) chk("wait_done_timeout", int'(done), int'(v));
    endtask

    task automatic wait_gnt(input logic [1:0] v);
        int n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (gnt != v && n < 64);
        if (gnt != v) chk("wait_gnt_timeout", int'(gnt), int'(v));
    endtask

    task automatic wait_q(input int v);
        int n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (int'(q) != v && n < 64);
        if (int'(q) != v) chk("wait_q_timeout", int'(q), v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst  = 1'b0;
        req  = 2'b00;
        lim0 = '0;
        lim1 = '0;
        #12;
        chk("reset_gnt", int'(gnt), 0);
        chk("reset_q", int'(q), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_busy", int'(busy), 0);
        @(negedge clk);
        rst = 1'b1;

        // both request: 0 first (lim 3), then 1 (lim 5)
        push(EV_G, 1, 0, -1); push(EV_D, 1, 3, 4); push(EV_R, 0, 0, 0);
        push(EV_G, 2, 0, 1);  push(EV_D, 2, 5, 6); push(EV_R, 0, 0, 0);
        @(posedge clk); #1;
        lim0 = 4'd3; lim1 = 4'd5; req = 2'b11;
        wait_done(2'b01);
        req = 2'b10;
        wait_done(2'b10);
        req = 2'b00;
        repeat (3) @(posedge clk);
        #1;

        // lim0=0: done one cycle after grant
        push(EV_G, 1, 0, -1); push(EV_D, 1, 0, 1); push(EV_R, 0, 0, 0);
        lim0 = 4'd0; req = 2'b01;
        wait_done(2'b01);
        req = 2'b00;
        repeat (3) @(posedge clk);
        #1;

        // full-scale count, no wrap
        push(EV_G, 2, 0, -1); push(EV_D, 2, 15, 16); push(EV_R, 0, 0, 0);
        lim1 = 4'd15; req = 2'b10;
        wait_done(2'b10);
        req = 2'b00;
        repeat (3) @(posedge clk);
        #1;

        // abort at q=4, requester 1 takes over
        push(EV_G, 1, 0, -1); push(EV_R, 0, 0, 0);
        push(EV_G, 2, 0, 1);  push(EV_D, 2, 1, 2); push(EV_R, 0, 0, 0);
        lim0 = 4'd9; req = 2'b01;
        wait_q(4);
        lim1 = 4'd1; req = 2'b10;
        wait_done(2'b10);
        req = 2'b00;
        repeat (3) @(posedge clk);
        #1;

        // continuous contention, alternating grants, mid-run lim edits
        for (int i = 0; i < 2; i++) begin
            push(EV_G, 1, 0, (i == 0) ? -1 : 1); push(EV_D, 1, 2, 3); push(EV_R, 0, 0, 0);
            push(EV_G, 2, 0, 1);                 push(EV_D, 2, 2, 3); push(EV_R, 0, 0, 0);
        end
        lim0 = 4'd2; lim1 = 4'd2; req = 2'b11;
        wait_gnt(2'b01);
        lim0 = 4'd7;
        wait_gnt(2'b10);
        lim0 = 4'd2; lim1 = 4'd9;
        wait_gnt(2'b01);
        lim1 = 4'd2; lim0 = 4'd11;
        wait_gnt(2'b10);
        lim1 = 4'd13;
        wait_done(2'b10);
        req = 2'b00;
        repeat (3) @(posedge clk);
        #1;

        // serve 0 (pointer now favours 1), then async reset at q=6
        push(EV_G, 1, 0, -1); push(EV_D, 1, 0, 1); push(EV_R, 0, 0, 0);
        push(EV_G, 1, 0, 1);  push(EV_R, 0, 0, 0);
        lim0 = 4'd0; req = 2'b01;
        wait_done(2'b01);
        lim0 = 4'd9;
        wait_q(6);
        #2;
        rst = 1'b0;
        #1;
        chk("async_q", int'(q), 0);
        chk("async_gnt", int'(gnt), 0);
        chk("async_busy", int'(busy), 0);
        chk("async_done", int'(done), 0);
        push(EV_G, 1, 0, -1); push(EV_D, 1, 1, 2); push(EV_R, 0, 0, 0);
        req = 2'b11; lim0 = 4'd1; lim1 = 4'd1;
        @(posedge clk);
        #3;
        rst = 1'b1;
        wait_done(2'b01);
        req = 2'b00;
        repeat (4) @(posedge clk);

        for (int n = 0; n < 20 && exp_q.size() != 0; n++) @(posedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
